// File: rtl/asmd_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// asmd_shift_add_multiplier
//
// Sequential unsigned shift-and-add multiplier organised as an ASMD block
// (a small datapath steered by a three-state controller). A start request
// captures both operands, then one multiplier bit is consumed per clock.
// After word_length iterations the full 2*word_length-bit product is
// published together with a ready flag.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous, active-low reset (clears every register)
//   start    - level request; accepted on a rising edge while IDLE or DONE
//   word0    - unsigned multiplicand, sampled only on the accepting edge
//   word1    - unsigned multiplier, sampled only on the accepting edge
//   product  - registered result, written only when a multiplication ends
//   ready    - registered flag, high while product holds a completed result
// ---------------------------------------------------------------------------
module asmd_shift_add_multiplier #(
    parameter int word_length = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [word_length-1:0]     word0,
    input  logic [word_length-1:0]     word1,
    output logic [2*word_length-1:0]   product,
    output logic                       ready
);

    localparam int PW = 2 * word_length;
    localparam int CW = $clog2(word_length + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q,   state_d;
    logic [PW-1:0]          mcand_q,   mcand_d;
    logic [word_length-1:0] mplier_q,  mplier_d;
    logic [PW-1:0]          acc_q,     acc_d;
    logic [CW-1:0]          count_q,   count_d;
    logic [PW-1:0]          product_q, product_d;
    logic                   ready_q,   ready_d;

    // Accumulator value after this iteration's conditional add; it is both
    // the next acc and, on the final iteration, the value published.
    logic [PW-1:0]          acc_sum;

    // State and datapath registers; everything clears on reset so no X can
    // ever reach the outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state and datapath control. Every register holds by default;
    // each state only overrides what it changes.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        ready_d   = ready_q;
        acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == IDLE) begin
                    ready_d = 1'b0;
                end
                // A new request is accepted from either resting state;
                // product keeps the old result until the new one lands.
                if (start) begin
                    mcand_d  = {{word_length{1'b0}}, word0};
                    mplier_d = word1;
                    acc_d    = '0;
                    count_d  = '0;
                    ready_d  = 1'b0;
                    state_d  = BUSY;
                end
            end

            BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                // The edge on which count reaches word_length is the last
                // iteration, so the sum including this add is final.
                if (count_q == CW'(word_length - 1)) begin
                    product_d = acc_sum;
                    ready_d   = 1'b1;
                    state_d   = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product = product_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_asmd_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_asmd_shift_add_multiplier
//
// Self-checking bench for asmd_shift_add_multiplier. Expected results come
// from plain integer multiplication and a fixed latency of word_length edges
// after the accepting edge; the last published product is tracked so the
// hold behaviour between results can be checked as well.
// ---------------------------------------------------------------------------
module tb_asmd_shift_add_multiplier;

    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic          clk;
    logic          reset;
    logic          start;
    logic [W-1:0]  word0;
    logic [W-1:0]  word1;
    logic [PW-1:0] product;
    logic          ready;

    int checkCount;
    int errorCount;
    int lastProduct;

    asmd_shift_add_multiplier #(
        .word_length(W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .word0   (word0),
        .word1   (word1),
        .product (product),
        .ready   (ready)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck run still reports and ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Runs one multiplication from an idle/done state with start pulsed for
    // the accepting edge only. Optionally scrambles operands while busy.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
        int expected;
        expected = int'(a) * int'(b);
        @(negedge clk);
        word0 = a;
        word1 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("accept_ready", int'(ready), 0);
        checkOutput("accept_product_hold", int'(product), lastProduct);
        start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            if (scramble) begin
                word0 = W'($urandom);
                word1 = W'($urandom);
            end
            @(posedge clk);
            #1;
            if (i < W) begin
                checkOutput("busy_ready", int'(ready), 0);
                checkOutput("busy_product_hold", int'(product), lastProduct);
            end else begin
                checkOutput("done_ready", int'(ready), 1);
                checkOutput("done_product", int'(product), expected);
                lastProduct = expected;
            end
        end
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        lastProduct = 0;
        reset = 1'b0;
        start = 1'b0;
        word0 = '0;
        word1 = '0;

        // Reset held for 10 cycles: outputs must stay cleared.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_product", int'(product), 0);
            checkOutput("reset_ready", int'(ready), 0);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_ready", int'(ready), 0);
        checkOutput("idle_product", int'(product), 0);

        // Directed operands, including corner values.
        applyStimulus(4'h5, 4'h3, 1'b0);
        checkOutput("5x3_literal", int'(product), 8'h0F);
        applyStimulus(4'hF, 4'hF, 1'b1);
        checkOutput("FxF_literal", int'(product), 8'hE1);
        applyStimulus(4'h0, 4'hB, 1'b1);
        checkOutput("0xB_literal", int'(product), 8'h00);
        applyStimulus(4'hA, 4'h1, 1'b0);
        checkOutput("Ax1_literal", int'(product), 8'h0A);

        // DONE with start low holds the result indefinitely.
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("done_hold_ready", int'(ready), 1);
            checkOutput("done_hold_product", int'(product), lastProduct);
        end

        // Start held high: 6*7 then 9*2 back to back.
        @(negedge clk);
        word0 = 4'd6;
        word1 = 4'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("b2b_accept1_ready", int'(ready), 0);
        for (int i = 1; i <= W; i++) begin
            word0 = W'($urandom);
            word1 = W'($urandom);
            @(posedge clk);
            #1;
            checkOutput("b2b_run1_ready", int'(ready), (i == W) ? 1 : 0);
        end
        checkOutput("b2b_result1", int'(product), 8'h2A);
        word0 = 4'd9;
        word1 = 4'd2;
        @(posedge clk);
        #1;
        checkOutput("b2b_accept2_ready", int'(ready), 0);
        checkOutput("b2b_accept2_product", int'(product), 8'h2A);
        start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            word0 = W'($urandom);
            word1 = W'($urandom);
            @(posedge clk);
            #1;
            checkOutput("b2b_run2_ready", int'(ready), (i == W) ? 1 : 0);
        end
        checkOutput("b2b_result2", int'(product), 8'h12);
        lastProduct = 8'h12;

        // Reset pulsed during the second busy cycle of 5*3.
        @(negedge clk);
        word0 = 4'd5;
        word1 = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_product", int'(product), 0);
        checkOutput("async_reset_ready", int'(ready), 0);
        lastProduct = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_ready", int'(ready), 0);
        applyStimulus(4'h5, 4'h3, 1'b0);

        // Random operands against plain multiplication.
        for (int n = 0; n < 24; n++) begin
            applyStimulus(W'($urandom), W'($urandom), n[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/asmd_shift_add_multiplier.md
Name: asmd_shift_add_multiplier

Overview:
- Sequential unsigned shift-and-add multiplier built as an ASMD (datapath plus FSM) block.
- On a start request it captures two word_length-bit operands and iterates one multiplier bit per clock.
- It then publishes the 2*word_length-bit product with a ready flag.
- A synthesized gate-level netlist of this block must be cycle-for-cycle equivalent on product and ready.

Parameters:
- word_length, 4, width of each unsigned operand; product is 2*word_length bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level request to begin a multiplication; sampled on the rising clk edge.
- word0  input  word_length  unsigned multiplicand; sampled only on the accepting edge.
- word1  input  word_length  unsigned multiplier; sampled only on the accepting edge.
- product  output  2*word_length  registered result of word0*word1.
- ready  output  1  registered flag: product holds a completed result.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low.
- Reset (reset=0), immediate and independent of clk:
  - state=IDLE, product=0, ready=0.
  - Internal multiplicand, multiplier, accumulator and counter all cleared.
- Internal registers:
  - mcand, 2*word_length bits.
  - mplier, word_length bits.
  - acc, 2*word_length bits.
  - count, ceil(log2(word_length+1)) bits.
- States: IDLE, BUSY, DONE.
- IDLE, start=0: hold. ready=0, product holds.
- IDLE or DONE, start=1 (accepting edge):
  - mcand={zeros,word0}, mplier=word1, acc=0, count=0.
  - ready<=0, state<=BUSY.
  - product keeps its previous value.
- BUSY, every edge (start ignored):
  - if mplier[0]=1 then acc<=acc+mcand.
  - mcand<=mcand<<1, mplier<=mplier>>1, count<=count+1.
  - On the edge where count reaches word_length: product<=final acc value (including this iteration's add), ready<=1, state<=DONE.
- Latency:
  - Accepting edge is edge 0.
  - ready rises and product is valid after edge word_length (4 for default), i.e. word_length+1 rising edges after start is first seen.
  - The iteration count is fixed; there is no early termination for zero operands.
- DONE, start=0: hold product and ready=1 indefinitely.
- DONE, start=1: accepted as a new request (as above). ready drops on that edge and product keeps the old result until the new one is written.
  - A continuously held start therefore yields back-to-back multiplications, with ready high for exactly one cycle between them.
- Arithmetic:
  - Unsigned only. The full 2*word_length-bit result is exact (max (2^W-1)^2 fits); no overflow or truncation.
- Operand changes on word0/word1 while BUSY or DONE have no effect on the current result.
- Reset asserted mid-BUSY: computation abandoned, outputs forced to reset values. After release the block is in IDLE.
- No X propagation: every register has a defined reset value. Outputs never show intermediate acc values.

Test Plan:
- Hold reset=0 for 10 cycles, start=0 -> product=8'h00, ready=0 throughout. Release reset -> still IDLE, ready=0.
- word0=4'h5, word1=4'h3, start=1 -> ready low on the accepting edge, rises exactly 4 edges later. product=8'h0F (15) when ready=1; product equals word0*word1 computed by the bench model.
- Corner operands:
  - 4'hF*4'hF -> 8'hE1.
  - 4'h0*4'hB -> 8'h00.
  - 4'hA*4'h1 -> 8'h0A.
  - Each with identical latency.
- Start held high across two requests (6*7, then operands changed to 9*2 during DONE):
  - ready pulses one cycle between results.
  - product goes 8'h2A then 8'h12.
  - Operand changes during BUSY do not affect the in-flight result.
- Reset pulsed low during the 2nd BUSY cycle of 5*3 -> product=0 and ready=0 immediately (asynchronously). A fresh start after release gives 8'h0F.
- Run all of the above with the RTL and the gate-level netlist side by side -> product and ready identical on every cycle.
